// File: rtl/fp_add_sub.sv
// Four-stage pipelined binary32 adder/subtractor: q = a + b when opSel=1, q = a - b when opSel=0.
// Denormal inputs and tiny results flush to zero; rounding is nearest-even.
module fp_add_sub (
   input  logic        clk,
   input  logic        areset,
   input  logic        en,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        opSel,
   output logic [31:0] q
);

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      logic       found;
      n     = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (found || v[i]) begin
            found = 1'b1;
         end else begin
            n = n + 5'd1;
         end
      end
      return n;
   endfunction

   logic        sa_s, sb_s, a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
   logic [7:0]  ea_s, eb_s, ex_s, ey_s, diff_s;
   logic [23:0] ma_s, mb_s, mx_s, my_s;
   logic        sx_s, swap_s, spec_s;
   logic [31:0] spec_val_s;

   logic        s1_spec_r, s1_sx_r, s1_eff_sub_r;
   logic [31:0] s1_spec_val_r;
   logic [7:0]  s1_ex_r, s1_diff_r;
   logic [23:0] s1_mx_r, s1_my_r;

   logic [4:0]  shamt_s;
   logic [49:0] wide_s;
   logic [26:0] xa_s, ya_s;
   logic [27:0] sum_s;

   logic        s2_spec_r, s2_s_r;
   logic [31:0] s2_spec_val_r;
   logic [7:0]  s2_e_r;
   logic [27:0] s2_sum_r;

   logic [4:0]  lz_s;
   logic [26:0] norm_m_s;
   logic [9:0]  norm_e_s;
   logic        norm_zero_s;

   logic        s3_spec_r, s3_s_r, s3_zero_r;
   logic [31:0] s3_spec_val_r;
   logic [9:0]  s3_e_r;
   logic [26:0] s3_m_r;

   logic        round_up_s, underflow_s;
   logic [24:0] rnd_s;
   logic [22:0] frac_s;
   logic [9:0]  exp_s;
   logic [31:0] result_s;

   // Unpack, classify, pick specials, order operands by magnitude.
   always_comb begin
      sa_s     = a[31];
      sb_s     = b[31] ^ ~opSel;
      ea_s     = a[30:23];
      eb_s     = b[30:23];
      a_zero_s = (ea_s == 8'd0);
      b_zero_s = (eb_s == 8'd0);
      a_inf_s  = (ea_s == 8'hFF) && (a[22:0] == 23'd0);
      b_inf_s  = (eb_s == 8'hFF) && (b[22:0] == 23'd0);
      a_nan_s  = (ea_s == 8'hFF) && (a[22:0] != 23'd0);
      b_nan_s  = (eb_s == 8'hFF) && (b[22:0] != 23'd0);
      ma_s     = a_zero_s ? 24'd0 : {1'b1, a[22:0]};
      mb_s     = b_zero_s ? 24'd0 : {1'b1, b[22:0]};
      if (a_nan_s || b_nan_s) begin
         spec_s     = 1'b1;
         spec_val_s = 32'h7FC0_0000;
      end else if (a_inf_s && b_inf_s && (sa_s != sb_s)) begin
         spec_s     = 1'b1;
         spec_val_s = 32'h7FC0_0000;
      end else if (a_inf_s) begin
         spec_s     = 1'b1;
         spec_val_s = {sa_s, 8'hFF, 23'd0};
      end else if (b_inf_s) begin
         spec_s     = 1'b1;
         spec_val_s = {sb_s, 8'hFF, 23'd0};
      end else if (a_zero_s && b_zero_s) begin
         spec_s     = 1'b1;
         spec_val_s = {sa_s & sb_s, 31'd0};
      end else begin
         spec_s     = 1'b0;
         spec_val_s = 32'd0;
      end
      swap_s = ({eb_s, mb_s} > {ea_s, ma_s});
      if (swap_s) begin
         sx_s = sb_s;
         ex_s = eb_s;
         mx_s = mb_s;
         ey_s = ea_s;
         my_s = ma_s;
      end else begin
         sx_s = sa_s;
         ex_s = ea_s;
         mx_s = ma_s;
         ey_s = eb_s;
         my_s = mb_s;
      end
      diff_s = ex_s - ey_s;
   end

   // Stage 1 register.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         s1_spec_r     <= 1'b0;
         s1_spec_val_r <= 32'd0;
         s1_sx_r       <= 1'b0;
         s1_eff_sub_r  <= 1'b0;
         s1_ex_r       <= 8'd0;
         s1_diff_r     <= 8'd0;
         s1_mx_r       <= 24'd0;
         s1_my_r       <= 24'd0;
      end else if (en) begin
         s1_spec_r     <= spec_s;
         s1_spec_val_r <= spec_val_s;
         s1_sx_r       <= sx_s;
         s1_eff_sub_r  <= sa_s ^ sb_s;
         s1_ex_r       <= ex_s;
         s1_diff_r     <= diff_s;
         s1_mx_r       <= mx_s;
         s1_my_r       <= my_s;
      end
   end

   // Align the smaller mantissa keeping guard/round plus a sticky bit, then add or subtract.
   always_comb begin
      shamt_s = (s1_diff_r > 8'd26) ? 5'd26 : s1_diff_r[4:0];
      wide_s  = {s1_my_r, 26'd0} >> shamt_s;
      ya_s    = {wide_s[49:24], |wide_s[23:0]};
      xa_s    = {s1_mx_r, 3'b000};
      if (s1_eff_sub_r) begin
         sum_s = {1'b0, xa_s} - {1'b0, ya_s};
      end else begin
         sum_s = {1'b0, xa_s} + {1'b0, ya_s};
      end
   end

   // Stage 2 register.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         s2_spec_r     <= 1'b0;
         s2_spec_val_r <= 32'd0;
         s2_s_r        <= 1'b0;
         s2_e_r        <= 8'd0;
         s2_sum_r      <= 28'd0;
      end else if (en) begin
         s2_spec_r     <= s1_spec_r;
         s2_spec_val_r <= s1_spec_val_r;
         s2_s_r        <= s1_sx_r;
         s2_e_r        <= s1_ex_r;
         s2_sum_r      <= sum_s;
      end
   end

   // Normalize so the leading one lands at bit 26; a carry folds its lost bit into sticky.
   always_comb begin
      lz_s        = lzc27(s2_sum_r[26:0]);
      norm_zero_s = (s2_sum_r == 28'd0);
      if (s2_sum_r[27]) begin
         norm_m_s = {s2_sum_r[27:2], s2_sum_r[1] | s2_sum_r[0]};
         norm_e_s = {2'b00, s2_e_r} + 10'd1;
      end else begin
         norm_m_s = s2_sum_r[26:0] << lz_s;
         norm_e_s = {2'b00, s2_e_r} - {5'd0, lz_s};
      end
   end

   // Stage 3 register.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         s3_spec_r     <= 1'b0;
         s3_spec_val_r <= 32'd0;
         s3_s_r        <= 1'b0;
         s3_zero_r     <= 1'b0;
         s3_e_r        <= 10'd0;
         s3_m_r        <= 27'd0;
      end else if (en) begin
         s3_spec_r     <= s2_spec_r;
         s3_spec_val_r <= s2_spec_val_r;
         s3_s_r        <= s2_s_r;
         s3_zero_r     <= norm_zero_s;
         s3_e_r        <= norm_e_s;
         s3_m_r        <= norm_m_s;
      end
   end

   // Round to nearest even, renormalize on carry-out, pack and resolve specials.
   always_comb begin
      round_up_s  = s3_m_r[2] & (s3_m_r[1] | s3_m_r[0] | s3_m_r[3]);
      rnd_s       = {1'b0, s3_m_r[26:3]} + {24'd0, round_up_s};
      underflow_s = s3_e_r[9] || (s3_e_r == 10'd0);
      if (rnd_s[24]) begin
         frac_s = rnd_s[23:1];
         exp_s  = s3_e_r + 10'd1;
      end else begin
         frac_s = rnd_s[22:0];
         exp_s  = s3_e_r;
      end
      if (s3_spec_r) begin
         result_s = s3_spec_val_r;
      end else if (s3_zero_r) begin
         result_s = 32'd0;
      end else if (underflow_s) begin
         result_s = {s3_s_r, 31'd0};
      end else if (exp_s >= 10'd255) begin
         result_s = {s3_s_r, 8'hFF, 23'd0};
      end else begin
         result_s = {s3_s_r, exp_s[7:0], frac_s};
      end
   end

   // Output register.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         q <= 32'd0;
      end else if (en) begin
         q <= result_s;
      end
   end

endmodule

// File: tb/tb_fp_add_sub.sv
// Bench for fp_add_sub: exact-integer reference model behind a 4-deep enabled delay line,
// directed vectors, latency/stall/async-reset checks and a randomized stream.
module tb_fp_add_sub;

   logic        clk, areset, en, opSel;
   logic [31:0] a, b, q;
   logic [31:0] hist [0:3];
   int          errors, checks;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic [31:0] e;
   } vec_t;
   vec_t vecs [0:16];

   fp_add_sub dut (
      .clk    (clk),
      .areset (areset),
      .en     (en),
      .a      (a),
      .b      (b),
      .opSel  (opSel),
      .q      (q)
   );

   always #5 clk = ~clk;

   // Exact sum of the two operands on a common integer scale, then nearest-even rounding.
   function automatic logic [31:0] fp_model(input logic [31:0] av, input logic [31:0] bv, input logic op);
      logic         sa, sb, s;
      int           ea, eb, emin, p, E, sh;
      logic [319:0] X, Y, S, top, rem, half;
      sa = av[31];
      sb = bv[31] ^ ~op;
      ea = int'(av[30:23]);
      eb = int'(bv[30:23]);
      if ((ea == 255 && av[22:0] != 23'd0) || (eb == 255 && bv[22:0] != 23'd0)) return 32'h7FC00000;
      if (ea == 255 && eb == 255 && sa != sb) return 32'h7FC00000;
      if (ea == 255) return {sa, 8'hFF, 23'd0};
      if (eb == 255) return {sb, 8'hFF, 23'd0};
      if (ea == 0 && eb == 0) return {sa & sb, 31'd0};
      if (ea == 0) return {sb, bv[30:0]};
      if (eb == 0) return av;
      emin = (ea < eb) ? ea : eb;
      X = {296'd0, 1'b1, av[22:0]} << (ea - emin);
      Y = {296'd0, 1'b1, bv[22:0]} << (eb - emin);
      if (sa == sb) begin
         S = X + Y; s = sa;
      end else if (X > Y) begin
         S = X - Y; s = sa;
      end else if (Y > X) begin
         S = Y - X; s = sb;
      end else begin
         return 32'h00000000;
      end
      p = 0;
      for (int i = 0; i < 320; i++) if (S[i]) p = i;
      E = p + emin - 23;
      if (E <= 0) return {s, 31'd0};
      if (p > 23) begin
         sh   = p - 23;
         top  = S >> sh;
         rem  = S & ((320'd1 << sh) - 320'd1);
         half = 320'd1 << (sh - 1);
         if (rem > half || (rem == half && top[0])) top = top + 320'd1;
      end else begin
         top = S << (23 - p);
      end
      if (top[24]) begin
         top = top >> 1;
         E   = E + 1;
      end
      if (E >= 255) return {s, 8'hFF, 23'd0};
      return {s, E[7:0], top[22:0]};
   endfunction

   function automatic logic [31:0] rnd_op(input int base_e);
      int          sel, e;
      logic [31:0] r;
      sel = $urandom_range(0, 9);
      case (sel)
         0: begin
            case ($urandom_range(0, 6))
               0: r = 32'h00000000;
               1: r = 32'h80000000;
               2: r = 32'h7F800000;
               3: r = 32'hFF800000;
               4: r = 32'h7FC00001;
               5: r = 32'h00000123;
               default: r = 32'h7F7FFFFF;
            endcase
         end
         1, 2: r = $urandom;
         default: begin
            e = base_e + int'($urandom_range(0, 6)) - 3;
            if (e < 1) e = 1;
            if (e > 254) e = 254;
            r = {1'($urandom_range(0, 1)), e[7:0], 23'($urandom)};
         end
      endcase
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
      end
   endtask

   // Drive one cycle; the delay line advances only on enabled edges.
   task automatic step(input logic e, input logic [31:0] av, input logic [31:0] bv, input logic op);
      a = av; b = bv; opSel = op; en = e;
      @(posedge clk);
      if (e) begin
         hist[3] = hist[2];
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = fp_model(av, bv, op);
      end
      @(negedge clk);
      check("pipe", q, hist[3]);
   endtask

   initial begin
      clk = 1'b0; areset = 1'b0; en = 1'b0; a = 32'd0; b = 32'd0; opSel = 1'b0;
      errors = 0; checks = 0;
      for (int i = 0; i < 4; i++) hist[i] = 32'd0;
      vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'h40400000};
      vecs[1]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'hBF800000};
      vecs[2]  = '{32'h40A00000, 32'h40400000, 1'b1, 32'h41000000};
      vecs[3]  = '{32'h40A00000, 32'h40400000, 1'b0, 32'h40000000};
      vecs[4]  = '{32'hC0000000, 32'h40400000, 1'b1, 32'h3F800000};
      vecs[5]  = '{32'hC0000000, 32'h40400000, 1'b0, 32'hC0A00000};
      vecs[6]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000};
      vecs[7]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000};
      vecs[8]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h00000000};
      vecs[9]  = '{32'h80000000, 32'h80000000, 1'b1, 32'h80000000};
      vecs[10] = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F800000};
      vecs[11] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 32'h7F800000};
      vecs[12] = '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7FC00000};
      vecs[13] = '{32'h00000001, 32'h00000000, 1'b1, 32'h00000000};
      vecs[14] = '{32'h80000000, 32'h00000000, 1'b0, 32'h80000000};
      vecs[15] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000};
      vecs[16] = '{32'h3F800000, 32'h7FC00000, 1'b1, 32'h7FC00000};

      #1 areset = 1'b1;
      #2 check("reset_state", q, 32'h00000000);
      @(negedge clk);
      @(negedge clk);
      areset = 1'b0;

      for (int i = 0; i < 17; i++) check($sformatf("model_vec%0d", i), fp_model(vecs[i].a, vecs[i].b, vecs[i].op), vecs[i].e);

      step(1'b1, 32'h3F800000, 32'h40000000, 1'b1);
      check("latency_edge1", q, 32'h00000000);
      step(1'b1, 32'h00000000, 32'h00000000, 1'b1);
      check("latency_edge2", q, 32'h00000000);
      step(1'b1, 32'h00000000, 32'h00000000, 1'b1);
      check("latency_edge3", q, 32'h00000000);
      step(1'b1, 32'h00000000, 32'h00000000, 1'b1);
      check("latency_edge4", q, 32'h40400000);

      for (int i = 0; i < 17; i++) step(1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
      for (int i = 0; i < 4; i++) step(1'b1, 32'h00000000, 32'h00000000, 1'b1);

      step(1'b1, 32'h3F800000, 32'h40000000, 1'b0);
      step(1'b1, 32'h40A00000, 32'h40400000, 1'b1);
      step(1'b1, 32'h40A00000, 32'h40400000, 1'b0);
      step(1'b1, 32'hC0000000, 32'h40400000, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
         check("stall_hold", q, 32'hBF800000);
      end
      step(1'b1, 32'h00000000, 32'h00000000, 1'b1);
      check("resume_1", q, 32'h41000000);
      step(1'b1, 32'h00000000, 32'h00000000, 1'b1);
      check("resume_2", q, 32'h40000000);
      step(1'b1, 32'h00000000, 32'h00000000, 1'b1);
      check("resume_3", q, 32'h3F800000);

      #2 areset = 1'b1;
      #1 check("reset_async", q, 32'h00000000);
      for (int i = 0; i < 4; i++) hist[i] = 32'd0;
      @(negedge clk);
      check("reset_held", q, 32'h00000000);
      areset = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         int base_e;
         base_e = $urandom_range(1, 254);
         step(($urandom_range(0, 3) != 0), rnd_op(base_e), rnd_op(base_e), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
